// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data-cache controller between the MEM stage
// and a line-wide off-chip memory with a request/acknowledge handshake.
module dcache_ctrl #(
    parameter int unsigned LINES     = 16,
    parameter int unsigned LINE_BITS = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int unsigned IdxW = $clog2(LINES);
    localparam int unsigned TagW = 28 - IdxW;

    typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

    state_e                 state_q;
    logic [LINES-1:0]       valid_q;
    logic [LINES-1:0]       dirty_q;
    logic [TagW-1:0]        tag_q  [LINES];
    logic [LINE_BITS-1:0]   data_q [LINES];

    logic [IdxW-1:0] idx;
    logic [TagW-1:0] tag;
    logic [1:0]      off;
    logic            hit;
    logic            store_hit;
    logic            fill_done;
    logic            unused_addr_bits;

    assign idx              = cpu_addr_i[4 +: IdxW];
    assign tag              = cpu_addr_i[31 -: TagW];
    assign off              = cpu_addr_i[3:2];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign hit         = cpu_req_i & valid_q[idx] & (tag_q[idx] == tag);
    assign cpu_stall_o = cpu_req_i & ((state_q != StIdle) | ~hit);
    assign cpu_data_o  = data_q[idx][{off, 5'b0} +: 32];

    // The array has exactly one write source per edge: a store hit in IDLE or a fill.
    assign store_hit = (state_q == StIdle) & hit & cpu_we_i;
    assign fill_done = (state_q == StAllocate) & mem_ack_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (store_hit) begin
                        dirty_q[idx] <= 1'b1;
                    end else if (cpu_req_i && !hit) begin
                        state_q <= (valid_q[idx] && dirty_q[idx]) ? StWriteback : StAllocate;
                    end
                end
                StWriteback: begin
                    if (mem_ack_i) begin
                        dirty_q[idx] <= 1'b0;
                        state_q      <= StAllocate;
                    end
                end
                StAllocate: begin
                    if (mem_ack_i) begin
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tag and data storage is deliberately left out of reset; valid bits guard it.
    always_ff @(posedge clk_i) begin
        if (fill_done) begin
            data_q[idx] <= mem_data_i;
            tag_q[idx]  <= tag;
        end else if (store_hit) begin
            data_q[idx][{off, 5'b0} +: 32] <= cpu_data_i;
        end
    end

    always_comb begin
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        unique case (state_q)
            StWriteback: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = {tag_q[idx], idx, 4'b0};
                mem_data_o = data_q[idx];
            end
            StAllocate: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {tag, idx, 4'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a latency-programmable line memory answers requests
// and records every write-back and fill it acknowledges.
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         cpu_req_i = 1'b0;
    logic         cpu_we_i = 1'b0;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_data_i = '0;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_data_o;
    logic [127:0] mem_data_i = '0;
    logic         mem_ack_i;

    int checks = 0;
    int errors = 0;

    // memory model state
    int           lat = 3;
    int           cnt = 0;
    logic         ack_m = 1'b0;
    logic         spur = 1'b0;
    logic         prev_req = 1'b0;
    int           rises = 0;
    int           wb_cnt = 0;
    int           fill_cnt = 0;
    logic [31:0]  wb_addr = '0;
    logic [127:0] wb_data = '0;
    logic [31:0]  fill_addr = '0;
    logic [127:0] mem [logic [31:0]];

    assign mem_ack_i = ack_m | spur;

    dcache_ctrl #(.LINES(16), .LINE_BITS(128)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cpu_req_i  (cpu_req_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .cpu_stall_o(cpu_stall_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Unwritten lines read back as word k = 0xC000_0000 | (line address + 4k).
    function automatic logic [127:0] dflt(input logic [31:0] a);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[k*32 +: 32] = 32'hC000_0000 | (a + 32'(4 * k));
        return l;
    endfunction

    // Ack arrives in the lat-th cycle of each transaction; a back-to-back request restarts the count.
    always @(negedge clk_i) begin
        if (rst_i || !mem_req_o) begin
            cnt   = 0;
            ack_m = 1'b0;
        end else begin
            cnt   = ack_m ? 1 : cnt + 1;
            ack_m = (cnt == lat);
            if (ack_m) begin
                if (mem_we_o) begin
                    wb_cnt++;
                    wb_addr = mem_addr_o;
                    wb_data = mem_data_o;
                    mem[mem_addr_o] = mem_data_o;
                end else begin
                    fill_cnt++;
                    fill_addr  = mem_addr_o;
                    mem_data_i = mem.exists(mem_addr_o) ? mem[mem_addr_o] : dflt(mem_addr_o);
                end
            end
        end
        if (mem_req_o && !prev_req) rises++;
        prev_req = mem_req_o;
    end

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int stalls, output logic [31:0] rdata);
        cpu_req_i  = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_data_i = wdata;
        stalls     = 0;
        @(negedge clk_i);
        while (cpu_stall_o && stalls < 200) begin
            stalls++;
            @(negedge clk_i);
        end
        rdata = cpu_data_o;
        @(posedge clk_i);
        #1 cpu_req_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++; if (cpu_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", cpu_stall_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_req_o); end
        checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", mem_we_o); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_addr_o); end
        checks++; if (mem_data_o !== 128'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", mem_data_o); end
        rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_cold_load;
        int s; logic [31:0] d; int f0 = fill_cnt; int w0 = wb_cnt;
        access(1'b0, 32'h0000_0104, '0, s, d);
        checks++; if (s != 4) begin errors++; $display("FAIL cold_stall got %0d want 4", s); end
        checks++; if (d !== 32'hC000_0104) begin errors++; $display("FAIL cold_data got %h want c0000104", d); end
        checks++; if (fill_addr !== 32'h100) begin errors++; $display("FAIL cold_fill_addr got %h want 100", fill_addr); end
        checks++; if (fill_cnt - f0 != 1 || wb_cnt != w0) begin errors++; $display("FAIL cold_txn got fills %0d wbs %0d want 1 0", fill_cnt - f0, wb_cnt - w0); end
    endtask

    task automatic test_store_hit_evict;
        int s; logic [31:0] d; int r0; int f0; int w0;
        access(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, s, d);
        checks++; if (s != 0) begin errors++; $display("FAIL store_hit_stall got %0d want 0", s); end
        access(1'b0, 32'h0000_0104, '0, s, d);
        checks++; if (s != 0 || d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_hit_read got %0d/%h want 0/deadbeef", s, d); end
        r0 = rises; f0 = fill_cnt; w0 = wb_cnt;
        access(1'b0, 32'h0000_0204, '0, s, d);
        checks++; if (s != 7) begin errors++; $display("FAIL evict_stall got %0d want 7", s); end
        checks++; if (wb_addr !== 32'h100) begin errors++; $display("FAIL evict_wb_addr got %h want 100", wb_addr); end
        checks++; if (wb_data[63:0] !== 64'hDEAD_BEEF_C000_0100) begin errors++; $display("FAIL evict_wb_data got %h want deadbeefc0000100", wb_data[63:0]); end
        checks++; if (fill_addr !== 32'h200) begin errors++; $display("FAIL evict_fill_addr got %h want 200", fill_addr); end
        checks++; if (rises - r0 != 1 || wb_cnt - w0 != 1 || fill_cnt - f0 != 1) begin errors++; $display("FAIL evict_b2b got rises %0d wbs %0d fills %0d want 1 1 1", rises - r0, wb_cnt - w0, fill_cnt - f0); end
        checks++; if (d !== 32'hC000_0204) begin errors++; $display("FAIL evict_data got %h want c0000204", d); end
    endtask

    task automatic test_store_miss;
        int s; logic [31:0] d;
        access(1'b1, 32'h0000_0318, 32'h1234_5678, s, d);
        checks++; if (s != 4) begin errors++; $display("FAIL store_miss_stall got %0d want 4", s); end
        access(1'b0, 32'h0000_0318, '0, s, d);
        checks++; if (s != 0 || d !== 32'h1234_5678) begin errors++; $display("FAIL store_miss_read got %0d/%h want 0/12345678", s, d); end
        access(1'b0, 32'h0000_0314, '0, s, d);
        checks++; if (s != 0 || d !== 32'hC000_0314) begin errors++; $display("FAIL store_miss_neighbour got %0d/%h want 0/c0000314", s, d); end
        access(1'b0, 32'h0000_0418, '0, s, d);
        checks++; if (s != 7 || wb_addr !== 32'h310) begin errors++; $display("FAIL store_miss_dirty got %0d/%h want 7/310", s, wb_addr); end
        checks++; if (wb_data[95:64] !== 32'h1234_5678) begin errors++; $display("FAIL store_miss_wb_word got %h want 12345678", wb_data[95:64]); end
    endtask

    task automatic test_req_drop;
        int s; logic [31:0] d; int r0 = rises; int f0 = fill_cnt; int n = 0;
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_0520;
        repeat (2) @(negedge clk_i);
        cpu_req_i = 1'b0;
        while (fill_cnt == f0 && n < 20) begin n++; @(negedge clk_i); end
        repeat (5) @(negedge clk_i);
        checks++; if (fill_cnt - f0 != 1 || rises - r0 != 1) begin errors++; $display("FAIL drop_txn got fills %0d rises %0d want 1 1", fill_cnt - f0, rises - r0); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL drop_req_idle got %b want 0", mem_req_o); end
        @(posedge clk_i); #1;
        access(1'b0, 32'h0000_0520, '0, s, d);
        checks++; if (s != 0 || d !== 32'hC000_0520) begin errors++; $display("FAIL drop_line_valid got %0d/%h want 0/c0000520", s, d); end
    endtask

    task automatic test_spurious_ack;
        int s; logic [31:0] d; int r0 = rises;
        @(negedge clk_i);
        mem_data_i = {4{32'hBAD0_BAD0}};
        spur = 1'b1;
        @(negedge clk_i);
        spur = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++; if (mem_req_o !== 1'b0 || rises != r0) begin errors++; $display("FAIL spur_state got req %b rises %0d want 0 0", mem_req_o, rises - r0); end
        @(posedge clk_i); #1;
        access(1'b0, 32'h0000_0520, '0, s, d);
        checks++; if (s != 0 || d !== 32'hC000_0520) begin errors++; $display("FAIL spur_array got %0d/%h want 0/c0000520", s, d); end
        access(1'b0, 32'h0000_0204, '0, s, d);
        checks++; if (s != 0 || d !== 32'hC000_0204) begin errors++; $display("FAIL spur_array2 got %0d/%h want 0/c0000204", s, d); end
    endtask

    task automatic test_reset_mid_wb;
        int s; logic [31:0] d; int n = 0;
        access(1'b1, 32'h0000_0630, 32'hCAFE_F00D, s, d);
        checks++; if (s != 4) begin errors++; $display("FAIL rst_prep_stall got %0d want 4", s); end
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_0730;
        @(negedge clk_i);
        while (!(mem_req_o && mem_we_o) && n < 20) begin n++; @(negedge clk_i); end
        checks++; if (!(mem_req_o && mem_we_o && mem_addr_o == 32'h630)) begin errors++; $display("FAIL rst_wb_entry got req %b we %b addr %h want 1 1 630", mem_req_o, mem_we_o, mem_addr_o); end
        #2 rst_i = 1'b1;
        #1;
        checks++; if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0) begin errors++; $display("FAIL rst_async_req got %b/%b want 0/0", mem_req_o, mem_we_o); end
        cpu_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        access(1'b0, 32'h0000_0204, '0, s, d);
        checks++; if (s != 4 || d !== 32'hC000_0204) begin errors++; $display("FAIL rst_invalidated got %0d/%h want 4/c0000204", s, d); end
        access(1'b0, 32'h0000_0520, '0, s, d);
        checks++; if (s != 4) begin errors++; $display("FAIL rst_invalidated2 got %0d want 4", s); end
    endtask

    initial begin
        test_reset;
        test_cold_load;
        test_store_hit_evict;
        test_store_miss;
        test_req_drop;
        test_spurious_ack;
        test_reset_mid_wb;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data-cache controller between the MEM stage and the off-chip data memory.
- The MEM stage drives cpu_req_i = MemRead | MemWrite from the decoded control word, and cpu_we_i = MemWrite.
- The block holds tag/valid/dirty/data arrays and sequences write-back and line-fill transactions with a request/acknowledge handshake.
- It stalls the pipeline until the access hits.

Parameters:
- LINES, 16, number of cache lines; power of two, 2..256.
- LINE_BITS, 128, line width: 4 words of 32 bits; fixed to match the memory port width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- cpu_req_i  in  1  MEM-stage load/store valid.
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address; bits [1:0] ignored.
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data; valid when cpu_req_i=1, cpu_we_i=0 and cpu_stall_o=0.
- cpu_stall_o  out  1  freeze pipeline while 1.
- mem_req_o  out  1  memory transaction request.
- mem_we_o  out  1  1 = write-back, 0 = fill.
- mem_addr_o  out  32  line-aligned address; bits [3:0] = 0.
- mem_data_o  out  128  write-back line.
- mem_data_i  in  128  fill line.
- mem_ack_i  in  1  one-cycle completion pulse from memory.

Behaviour:
- Address split:
  - word offset = addr[3:2];
  - index = addr[3+log2(LINES):4];
  - tag = the remaining upper bits (LINES=16: index [7:4], tag [31:8]).
- Hit = cpu_req_i & valid[index] & (tag_array[index] == tag). Evaluated combinationally.
- cpu_stall_o = cpu_req_i & (state != IDLE | !hit). Combinational, so it asserts in the same cycle as the miss.
- cpu_data_o = selected word of data[index], combinational. When not a load hit it shows the current array word; it is don't-care, not forced to 0.
- Store hit in IDLE: at the clock edge, write the word into data[index][offset] and set dirty[index]=1. No stall.
- States: IDLE, WRITEBACK, ALLOCATE. Decisions from IDLE on a miss:
  - IDLE, miss, victim valid & dirty -> WRITEBACK.
  - IDLE, miss, victim clean or invalid -> ALLOCATE.
  - IDLE otherwise -> stay in IDLE.
- WRITEBACK:
  - mem_req_o=1, mem_we_o=1.
  - mem_addr_o = {victim tag, index, 4'b0}, mem_data_o = data[index].
  - On mem_ack_i: clear dirty[index] and go to ALLOCATE.
- ALLOCATE:
  - mem_req_o=1, mem_we_o=0, mem_addr_o = {tag, index, 4'b0}.
  - On mem_ack_i: data[index] <= mem_data_i, tag_array[index] <= tag, valid=1, dirty=0; go to IDLE.
- mem_req_o, mem_we_o and mem_addr_o decode from the registered state only. mem_req_o=0 in IDLE.
- Back-to-back handshake: WRITEBACK -> ALLOCATE holds mem_req_o high across the transition. Memory treats each ack as ending one transaction; the new request begins the cycle after the ack.
- Miss completion: after the fill, the access is re-evaluated in IDLE as a hit.
  - A store merges its word in that IDLE cycle and sets dirty.
  - Clean-miss penalty = L+1 stall cycles, where L = cycles from mem_req_o rising to mem_ack_i, L ≥ 1.
  - Dirty miss adds the write-back latency.
- mem_ack_i is ignored in IDLE.
- The CPU holds cpu_addr_i, cpu_we_i and cpu_data_i stable while stalled.
  - If cpu_req_i drops mid-miss, the current transaction still completes and the FSM returns to IDLE.
  - No abort is issued.
- Reset (rst_i=1, asynchronous, any state):
  - state = IDLE; all valid=0, dirty=0.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, cpu_stall_o=0 (cpu_req_i=0 held during reset).
  - Data and tag arrays are not reset.
  - An in-flight transaction is abandoned; memory must tolerate a dropped request.
- No simultaneous-event ambiguity: the array is written from only one source per edge (store hit in IDLE or fill in ALLOCATE).

Test Plan:
- Cold load: after reset, load 0x0000_0104 with memory returning line {D3,D2,D1,D0}, ack at L=3.
  - ALLOCATE at mem_addr_o 0x100, mem_we_o=0.
  - Stall lasts exactly 4 cycles, then cpu_data_o = D1.
- Store hit then evict: store 0xDEAD_BEEF to 0x104 (hits after the fill), then load 0x0000_0204 (same index 0, tag 0x2).
  - WRITEBACK to 0x100 with mem_data_o[63:32] = 0xDEAD_BEEF.
  - Then ALLOCATE to 0x200; req stays high across the ack.
- Store miss allocate: store to a clean miss.
  - Fill, then the word is merged in the IDLE cycle and dirty=1.
  - A subsequent load to the same address returns the stored value with no stall.
- Reset mid-WRITEBACK: assert rst_i asynchronously between clock edges.
  - mem_req_o falls immediately.
  - The next access to any address misses (valid cleared).
- cpu_req_i drops during ALLOCATE: fill still completes, the line becomes valid, and no second request is issued.
- Spurious mem_ack_i in IDLE: no state change and no array update.
